pingpong_frame_buffer: RTL and testbench
========================================

Name: pingpong_frame_buffer

Overview:
Parametrised double-bank (ping-pong) group buffer with an integrated bank-switch controller, replacing two discrete group RAMs plus the external switch mux between the frame filler and the frame former. The writer fills one bank while the reader serialises the other. Banks swap only on a reader frame-boundary request, and only when the writer has committed a complete group. Underrun and overrun are detected and counted; they are not silently tolerated.

Parameters:
DATA_W, 12, word width of both banks
ADDR_W, 10, address width; each bank holds 2**ADDR_W words
CNT_W, 8, width of the saturating error counters
FILL_VALUE, 0, word returned for a stale frame when STALE_FILL_EN is defined

Ports:
clk  in  1  single clock for all logic and both banks
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe into the current write bank
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_commit  in  1  one-cycle pulse: write bank holds a complete group
rd_en  in  1  read strobe from the current read bank
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data
swap_req  in  1  one-cycle pulse from the reader at a frame boundary
bank_sel  out  1  current read bank; write bank is ~bank_sel
frame_ready  out  1  write bank committed, waiting for a swap
stale  out  1  the current read frame is a repeat (an underrun occurred)
wr_count  out  ADDR_W+1  writes accepted since the last successful swap, saturating
underrun_cnt  out  CNT_W  swap_req without a commit, saturating
overrun_cnt  out  CNT_W  writes dropped because the bank was committed, saturating

Behaviour:
- Reset (async, rst_n=0):
  - bank_sel=0, frame_ready=0, stale=0.
  - rd_data=0, wr_count=0, underrun_cnt=0, overrun_cnt=0.
  - RAM contents are undefined.
- Controller states:
  - FILL (frame_ready=0): writes are accepted; wr_commit moves to READY.
  - READY (frame_ready=1): writes are dropped; a further wr_commit is ignored.
- Write path:
  - In FILL, wr_en writes wr_data to bank ~bank_sel at wr_addr.
  - wr_count increments, saturating at 2**ADDR_W.
  - In READY, wr_en is dropped and overrun_cnt increments.
- wr_en and wr_commit in the same cycle: the write is accepted first, then the state moves to READY.
- swap_req in READY (successful swap):
  - bank_sel toggles in the next cycle.
  - State returns to FILL; wr_count=0; stale=0.
- swap_req in FILL (underrun):
  - bank_sel is unchanged and underrun_cnt increments.
  - stale=1 until the next successful swap.
  - wr_count and the partial fill are kept.
- swap_req and wr_commit in the same cycle, from FILL: the commit is evaluated first, so the swap succeeds. Any same-cycle write lands in the outgoing write bank before the handover.
- Read path:
  - rd_data is updated one cycle after rd_en, from bank bank_sel sampled in the rd_en cycle.
  - rd_data holds its value while rd_en=0.
  - A read in a swap cycle uses the pre-swap bank.
- Read and write to the same address are always in different banks, so there is no hazard.
- Counters saturate at 2**CNT_W-1 and never wrap. Only reset clears them.
- rst_n asserted mid-frame: everything returns to reset values immediately. Any pending commit is lost.

Optional Feature:
STALE_FILL_EN
- Defined: while stale=1, every read returns FILL_VALUE instead of bank contents, so the frame former emits a filler frame.
- Undefined: while stale=1, reads return the old read bank, so the previous frame repeats.
- The stale flag and the counters behave identically in both builds.

Test Plan:
- Basic swap:
  - Stimulus: reset; write 1024 words (data=addr) to bank 1; wr_commit; swap_req; read addresses 0..1023.
  - Required: bank_sel=1; rd_data equals the address, one cycle after each rd_en; wr_count=1024 before the swap and 0 after.
- Underrun:
  - Stimulus: swap_req with no commit.
  - Required: bank_sel unchanged, underrun_cnt=1, stale=1.
  - Reads: 0x000 with STALE_FILL_EN (FILL_VALUE=0); prior frame data without it.
  - Recovery: a subsequent commit plus swap_req clears stale and toggles bank_sel.
- Overrun:
  - Stimulus: commit, then 5 writes before swap_req.
  - Required: overrun_cnt=5; the bank read after the swap is free of the dropped data.
- Simultaneous events:
  - Stimulus: wr_en (addr 7, data 0xABC), wr_commit and swap_req all in one cycle, from FILL.
  - Required: swap succeeds; reading address 7 after the swap returns 0xABC.
- Saturation:
  - Stimulus: 300 underruns with CNT_W=8.
  - Required: underrun_cnt=255 and holds.
- Reset mid-frame:
  - Stimulus: rst_n low after a commit, before the swap.
  - Required: immediately bank_sel=0, frame_ready=0, counters=0, rd_data=0.

Source files
------------

// File: rtl/pingpong_frame_buffer.sv
// -----------------------------------------------------------------------------
// pingpong_frame_buffer
//
// Double-bank (ping-pong) group buffer with its bank-switch controller. The
// writer fills bank ~bank_sel while the reader serialises bank bank_sel. The
// banks swap only when the reader asks at a frame boundary (swap_req) and the
// writer has committed a complete group (wr_commit). Underruns (swap without
// commit) and overruns (writes into a committed bank) are counted.
//
// Optional build macro: STALE_FILL_EN
//   defined   : while stale=1 every read returns FILL_VALUE (filler frame)
//   undefined : while stale=1 reads return the old read bank (frame repeats)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en/addr/data  write strobe into the write bank (~bank_sel)
//   wr_commit        pulse: write bank holds a complete group
//   rd_en/addr       read strobe from the read bank (bank_sel)
//   rd_data          registered read data, one cycle after rd_en, held otherwise
//   swap_req         pulse from the reader at a frame boundary
//   bank_sel         current read bank
//   frame_ready      controller state: 1 = READY (committed), 0 = FILL
//   stale            current read frame is a repeat after an underrun
//   wr_count         writes accepted since the last swap, saturating at 2**ADDR_W
//   underrun_cnt     saturating count of swap_req without commit
//   overrun_cnt      saturating count of writes dropped in READY
//
// Handshake: all strobes are single-cycle qualifiers sampled on the rising
// clock edge; there is no back-pressure, so a write in READY is dropped and
// counted rather than stalled.
// -----------------------------------------------------------------------------
module pingpong_frame_buffer #(
  parameter int                 DATA_W     = 12,
  parameter int                 ADDR_W     = 10,
  parameter int                 CNT_W      = 8,
  parameter logic [DATA_W-1:0]  FILL_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              swap_req,
  output logic              bank_sel,
  output logic              frame_ready,
  output logic              stale,
  output logic [ADDR_W:0]   wr_count,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic [CNT_W-1:0]  overrun_cnt
);

`ifdef STALE_FILL_EN
  localparam bit STALE_FILL = 1'b1;
`else
  localparam bit STALE_FILL = 1'b0;
`endif

  localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t state;

  // Both banks live in one array; the top address bit selects the bank.
  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  logic wr_accept;
  logic wr_drop;
  logic swap_ok;
  logic underrun;

  // The commit is evaluated before the swap, so a commit arriving in the
  // same cycle as swap_req already counts as a complete group.
  always_comb begin
    wr_accept = wr_en && (state == FILL);
    wr_drop   = wr_en && (state == READY);
    swap_ok   = swap_req && ((state == READY) || wr_commit);
    underrun  = swap_req && !swap_ok;
  end

  // The state register is the frame_ready output, so it is directly observable.
  assign frame_ready = (state == READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      bank_sel     <= 1'b0;
      stale        <= 1'b0;
      wr_count     <= '0;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (swap_ok) begin
        // A same-cycle write has already landed in the outgoing bank; the
        // count restarts for the new write bank.
        bank_sel <= ~bank_sel;
        state    <= FILL;
        wr_count <= '0;
        stale    <= 1'b0;
      end else begin
        if (wr_commit && (state == FILL)) begin
          state <= READY;
        end
        if (wr_accept && (wr_count != WR_MAX)) begin
          wr_count <= wr_count + (ADDR_W+1)'(1);
        end
        if (underrun) begin
          stale <= 1'b1;
        end
      end
      if (underrun && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
      if (wr_drop && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      end
    end
  end

  // Bank storage: not reset. Reads and writes always target opposite banks.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{~bank_sel, wr_addr}] <= wr_data;
    end
  end

  // Read register: bank_sel and stale are sampled in the rd_en cycle, so a
  // read issued in a swap cycle still uses the pre-swap bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (STALE_FILL && stale) begin
        rd_data <= FILL_VALUE;
      end else begin
        rd_data <= mem[{bank_sel, rd_addr}];
      end
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
module tb_pingpong_frame_buffer;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;

`ifdef STALE_FILL_EN
  localparam bit FILL_MODE = 1'b1;
`else
  localparam bit FILL_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_commit = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              swap_req = 1'b0;
  logic              bank_sel;
  logic              frame_ready;
  logic              stale;
  logic [ADDR_W:0]   wr_count;
  logic [CNT_W-1:0]  underrun_cnt;
  logic [CNT_W-1:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;

  pingpong_frame_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FILL_VALUE('0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_req(swap_req), .bank_sel(bank_sel), .frame_ready(frame_ready),
    .stale(stale), .wr_count(wr_count),
    .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
  endtask

  task automatic swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] exp);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    check($sformatf("%s[%0d]", tag, a), 32'(rd_data), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    step(); step();
    check("rst_bank_sel", 32'(bank_sel), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_stale", 32'(stale), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_underrun", 32'(underrun_cnt), 0);
    check("rst_overrun", 32'(overrun_cnt), 0);
    rst_n = 1'b1;
    step();

    // Basic swap: fill bank 1 with data=addr
    for (int a = 0; a < 1024; a++) write_word(ADDR_W'(a), DATA_W'(a));
    check("basic_wr_count_full", 32'(wr_count), 1024);
    write_word(10'd0, 12'd0);  // one extra write: count saturates at 1024
    check("basic_wr_count_sat", 32'(wr_count), 1024);
    commit();
    check("basic_frame_ready", 32'(frame_ready), 1);
    swap();
    check("basic_bank_sel", 32'(bank_sel), 1);
    check("basic_frame_ready_clr", 32'(frame_ready), 0);
    check("basic_wr_count_clr", 32'(wr_count), 0);
    for (int a = 0; a < 1024; a++) read_check("basic_rd", ADDR_W'(a), DATA_W'(a));
    step();
    check("basic_rd_hold", 32'(rd_data), 1023);

    // Underrun: partial fill of bank 0, swap without commit
    for (int a = 0; a < 4; a++) write_word(ADDR_W'(a), DATA_W'(12'h100 + a));
    swap();
    check("under_bank_sel", 32'(bank_sel), 1);
    check("under_cnt", 32'(underrun_cnt), 1);
    check("under_stale", 32'(stale), 1);
    check("under_wr_count_kept", 32'(wr_count), 4);
    read_check("under_rd", 10'd5, FILL_MODE ? 12'h000 : 12'd5);
    read_check("under_rd", 10'd1000, FILL_MODE ? 12'h000 : 12'd1000);
    // Recovery
    for (int a = 0; a < 16; a++) write_word(ADDR_W'(a), DATA_W'(12'h200 + a));
    check("recov_wr_count", 32'(wr_count), 20);
    commit();
    swap();
    check("recov_stale", 32'(stale), 0);
    check("recov_bank_sel", 32'(bank_sel), 0);
    check("recov_under_cnt", 32'(underrun_cnt), 1);
    read_check("recov_rd", 10'd3, 12'h203);
    read_check("recov_rd", 10'd10, 12'h20A);

    // Overrun: bank 1 gets 8 new words, then 5 dropped writes
    for (int a = 0; a < 8; a++) write_word(ADDR_W'(a), DATA_W'(12'h300 + a));
    commit();
    for (int a = 0; a < 5; a++) write_word(ADDR_W'(a), 12'hFFF);
    check("over_cnt", 32'(overrun_cnt), 5);
    check("over_wr_count", 32'(wr_count), 8);
    swap();
    check("over_bank_sel", 32'(bank_sel), 1);
    for (int a = 0; a < 5; a++) read_check("over_rd", ADDR_W'(a), DATA_W'(12'h300 + a));
    read_check("over_rd_old", 10'd20, 12'd20);

    // Simultaneous write + commit + swap from FILL (write bank 0)
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 12'hABC;
    wr_commit = 1'b1; swap_req = 1'b1;
    step();
    wr_en = 1'b0; wr_commit = 1'b0; swap_req = 1'b0;
    check("simul_bank_sel", 32'(bank_sel), 0);
    check("simul_frame_ready", 32'(frame_ready), 0);
    check("simul_wr_count", 32'(wr_count), 0);
    check("simul_under_cnt", 32'(underrun_cnt), 1);
    read_check("simul_rd", 10'd7, 12'hABC);
    read_check("simul_rd", 10'd3, 12'h203);

    // Saturation: 300 more underruns on top of the earlier one
    for (int i = 0; i < 300; i++) swap();
    check("sat_under_cnt", 32'(underrun_cnt), 255);
    swap();
    check("sat_under_hold", 32'(underrun_cnt), 255);
    check("sat_bank_sel", 32'(bank_sel), 0);
    check("sat_overrun_untouched", 32'(overrun_cnt), 5);

    // Recover, then build a pending commit and reset mid-frame
    write_word(10'd0, 12'h055);
    commit();
    swap();
    check("pre_rst_bank_sel", 32'(bank_sel), 1);
    check("pre_rst_stale", 32'(stale), 0);
    read_check("pre_rst_rd", 10'd0, 12'h055);
    read_check("pre_rst_rd", 10'd5, 12'h305);
    write_word(10'd1, 12'h0AA);
    commit();
    check("pre_rst_frame_ready", 32'(frame_ready), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bank_sel", 32'(bank_sel), 0);
    check("midrst_frame_ready", 32'(frame_ready), 0);
    check("midrst_stale", 32'(stale), 0);
    check("midrst_rd_data", 32'(rd_data), 0);
    check("midrst_wr_count", 32'(wr_count), 0);
    check("midrst_underrun", 32'(underrun_cnt), 0);
    check("midrst_overrun", 32'(overrun_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    // The pre-reset commit is gone, so this swap is an underrun
    swap();
    check("post_rst_bank_sel", 32'(bank_sel), 0);
    check("post_rst_underrun", 32'(underrun_cnt), 1);
    check("post_rst_stale", 32'(stale), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
